// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code sequence generator and its neighbours.
package gray_pkg;

  localparam int unsigned GRAY_WIDTH = 3;
  localparam int unsigned MAX_CNT    = (1 << GRAY_WIDTH) - 1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  function automatic logic [GRAY_WIDTH-1:0] bin2gray(input logic [GRAY_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/bin_to_gray_comb.sv
// Pure combinational binary-to-Gray encoder; also usable as a reference model.
module bin_to_gray_comb #(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray_c
);

  assign gray_c = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_seq_gen.sv
// Gray-code sequence source: up/down binary counter, load, valid/ready handshake
// and a one-cycle wrap pulse, all outputs registered.
module gray_seq_gen
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_WIDTH
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             en_in,
  input  logic             up_in,
  input  logic             load_in,
  input  logic [WIDTH-1:0] load_val_in,
  input  logic             ready_in,
  output logic [WIDTH-1:0] gray_out,
  output logic             valid_out,
  output logic             wrap_out
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] bin_nxt;
  logic [WIDTH-1:0] gray_nxt_c;
  logic             valid_nxt;
  logic             wrap_nxt;
  logic             xfer_c;

  assign xfer_c = valid_out && ready_in;

  // Gray code is encoded from the next counter value so gray_out tracks bin exactly.
  bin_to_gray_comb #(
    .WIDTH (WIDTH)
  ) u_enc (
    .bin    (bin_nxt),
    .gray_c (gray_nxt_c)
  );

  // State, counter and output registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= IDLE;
      bin       <= '0;
      gray_out  <= '0;
      valid_out <= 1'b0;
      wrap_out  <= 1'b0;
    end else begin
      state     <= state_nxt;
      bin       <= bin_nxt;
      gray_out  <= gray_nxt_c;
      valid_out <= valid_nxt;
      wrap_out  <= wrap_nxt;
    end
  end

  // Next state and counter; load overrides everything, including a same-edge transfer.
  always_comb begin
    state_nxt = state;
    bin_nxt   = bin;
    if (load_in) begin
      state_nxt = ACTIVE;
      bin_nxt   = load_val_in;
    end else begin
      unique case (state)
        IDLE: begin
          if (en_in) state_nxt = ACTIVE;
        end
        ACTIVE: begin
          if (xfer_c) begin
            bin_nxt   = up_in ? bin + WIDTH'(1) : bin - WIDTH'(1);
            state_nxt = en_in ? ACTIVE : IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Next values of the handshake and wrap outputs.
  always_comb begin
    valid_nxt = (state_nxt == ACTIVE);
    wrap_nxt  = 1'b0;
    if (!load_in && (state == ACTIVE) && xfer_c) begin
      wrap_nxt = up_in ? (bin == CNT_MAX) : (bin == '0);
    end
  end

endmodule

// File: tb/tb_gray_seq_gen.sv
// Directed scoreboard bench for gray_seq_gen: expected codes queued at drive time.
module tb_gray_seq_gen;

  logic       clk_in;
  logic       rst_n_in;
  logic       en_in;
  logic       up_in;
  logic       load_in;
  logic [2:0] load_val_in;
  logic       ready_in;
  logic [2:0] gray_out;
  logic       valid_out;
  logic       wrap_out;

  typedef struct packed {
    logic [2:0] gray;
    logic       valid;
    logic       wrap;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  gray_seq_gen #(.WIDTH(3)) dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .en_in       (en_in),
    .up_in       (up_in),
    .load_in     (load_in),
    .load_val_in (load_val_in),
    .ready_in    (ready_in),
    .gray_out    (gray_out),
    .valid_out   (valid_out),
    .wrap_out    (wrap_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  task automatic check_out(input string tag, input exp_t e);
    checks++;
    assert (gray_out === e.gray) else begin
      errors++;
      $error("FAIL %s gray: observed %b expected %b", tag, gray_out, e.gray);
    end
    checks++;
    assert (valid_out === e.valid) else begin
      errors++;
      $error("FAIL %s valid: observed %b expected %b", tag, valid_out, e.valid);
    end
    checks++;
    assert (wrap_out === e.wrap) else begin
      errors++;
      $error("FAIL %s wrap: observed %b expected %b", tag, wrap_out, e.wrap);
    end
  endtask

  // Drive one cycle of inputs, queue the expected registered result, compare after the edge.
  task automatic step(input string tag, input logic en, input logic up, input logic ld,
                      input logic [2:0] lv, input logic rdy,
                      input logic [2:0] eg, input logic ev, input logic ew);
    exp_t e;
    en_in       = en;
    up_in       = up;
    load_in     = ld;
    load_val_in = lv;
    ready_in    = rdy;
    exp_q.push_back('{gray: eg, valid: ev, wrap: ew});
    @(posedge clk_in);
    #1;
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL %s queue: observed empty expected entry", tag);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_out(tag, e);
    end
  endtask

  initial begin
    rst_n_in    = 1'b0;
    en_in       = 1'b0;
    up_in       = 1'b0;
    load_in     = 1'b0;
    load_val_in = 3'd0;
    ready_in    = 1'b0;
    #2;
    check_out("reset", '{gray: 3'b000, valid: 1'b0, wrap: 1'b0});
    #10 rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
    check_out("idle_after_reset", '{gray: 3'b000, valid: 1'b0, wrap: 1'b0});

    // Up count through a full wrap
    step("start",   1, 1, 0, 3'd0, 1, 3'b000, 1, 0);
    step("up1",     1, 1, 0, 3'd0, 1, 3'b001, 1, 0);
    step("up2",     1, 1, 0, 3'd0, 1, 3'b011, 1, 0);
    step("up3",     1, 1, 0, 3'd0, 1, 3'b010, 1, 0);
    step("up4",     1, 1, 0, 3'd0, 1, 3'b110, 1, 0);
    step("up5",     1, 1, 0, 3'd0, 1, 3'b111, 1, 0);
    step("up6",     1, 1, 0, 3'd0, 1, 3'b101, 1, 0);
    step("up7",     1, 1, 0, 3'd0, 1, 3'b100, 1, 0);
    step("up_wrap", 1, 1, 0, 3'd0, 1, 3'b000, 1, 1);
    step("up_post", 1, 1, 0, 3'd0, 1, 3'b001, 1, 0);
    step("up_011",  1, 1, 0, 3'd0, 1, 3'b011, 1, 0);

    // Backpressure holds the presented code regardless of en/up
    step("bp0", 0, 0, 0, 3'd0, 0, 3'b011, 1, 0);
    step("bp1", 1, 1, 0, 3'd0, 0, 3'b011, 1, 0);
    step("bp2", 0, 0, 0, 3'd0, 0, 3'b011, 1, 0);
    step("bp3", 1, 0, 0, 3'd0, 0, 3'b011, 1, 0);
    step("bp_release", 1, 1, 0, 3'd0, 1, 3'b010, 1, 0);

    // Load while stalled, then accept; load beats a same-edge wrapping transfer
    step("load5",        1, 1, 1, 3'd5, 0, 3'b111, 1, 0);
    step("load5_accept", 1, 1, 0, 3'd0, 1, 3'b101, 1, 0);
    step("load7_xfer",   1, 1, 1, 3'd7, 1, 3'b100, 1, 0);
    step("load0_nowrap", 1, 1, 1, 3'd0, 1, 3'b000, 1, 0);
    step("after_load0",  1, 1, 0, 3'd0, 1, 3'b001, 1, 0);

    // Drop en on a transfer, idle, then resume without skipping
    step("en_drop",   0, 1, 0, 3'd0, 1, 3'b011, 0, 0);
    step("idle_hold", 0, 1, 0, 3'd0, 1, 3'b011, 0, 0);
    step("en_resume", 1, 1, 0, 3'd0, 1, 3'b011, 1, 0);
    step("resume_up", 1, 1, 0, 3'd0, 1, 3'b010, 1, 0);
    step("to_110",    1, 1, 0, 3'd0, 0, 3'b010, 1, 0);
    step("at_110",    1, 1, 0, 3'd0, 1, 3'b110, 1, 0);
    step("dir_up",    1, 1, 0, 3'd0, 0, 3'b110, 1, 0);

    // Asynchronous reset mid-cycle while a code is pending
    #3;
    rst_n_in = 1'b0;
    en_in    = 1'b0;
    ready_in = 1'b0;
    #1;
    check_out("async_reset", '{gray: 3'b000, valid: 1'b0, wrap: 1'b0});
    @(posedge clk_in);
    #4 rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
    check_out("post_reset_idle", '{gray: 3'b000, valid: 1'b0, wrap: 1'b0});

    // Down count from reset, wrapping below zero, then a direction change
    step("dn_start", 1, 0, 0, 3'd0, 1, 3'b000, 1, 0);
    step("dn_wrap",  1, 0, 0, 3'd0, 1, 3'b100, 1, 1);
    step("dn6",      1, 0, 0, 3'd0, 1, 3'b101, 1, 0);
    step("dn5",      1, 0, 0, 3'd0, 1, 3'b111, 1, 0);
    step("dn4",      1, 0, 0, 3'd0, 1, 3'b110, 1, 0);
    step("dir_chg",  1, 1, 0, 3'd0, 1, 3'b111, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
